updn_counter_bcd: RTL and testbench

- Parametrised successor to the single-digit push-button counter.
- Debounces two active-low push buttons and turns each press into one up or down step.
- Holds a bounded count with a selectable wrap or saturate mode.
- Converts the count to NUM_DIG BCD digits with a sequential double-dabble engine, and drives one 7-segment pattern per digit for the board display.

---
 rtl/cnt_pkg.sv | 36 +++
 rtl/push_debounce.sv | 60 ++++++
 rtl/updn_counter_bcd.sv | 182 ++++++++++++++++++
 tb/tb_updn_counter_bcd.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_pkg.sv
// Shared types and helpers for the BCD up/down counter: converter state
// encoding and the active-low 7-segment lookup for the board display.
package cnt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

    // Index 10 is the blank pattern used for non-decimal digit codes.
    localparam int SEG_BLANK_IDX = 10;

    // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_TABLE [0:10] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b1111111   // blank
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        if (digit <= 4'd9) begin
            return SEG_TABLE[digit];
        end
        return SEG_TABLE[SEG_BLANK_IDX];
    endfunction

endpackage

// File: rtl/push_debounce.sv
// One push button: 2-FF synchroniser, stability counter and a one-cycle
// pulse when the accepted (active-low) level goes from released to pressed.
module push_debounce #(
    parameter int DEB_CYC = 1000000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Push,
    output logic o_Press
);

    localparam int CW = $clog2(DEB_CYC + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] stab_q, stab_d;
    logic          press_q, press_d;

    // Bring the raw button into the clock domain; idle level is released (1).
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= i_Push;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after DEB_CYC consecutive differing samples.
    always_comb begin
        level_d = level_q;
        stab_d  = '0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (stab_q == CW'(DEB_CYC - 1)) begin
                level_d = sync2_q;
                press_d = ~sync2_q;
            end else begin
                stab_d = stab_q + 1'b1;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            level_q <= 1'b1;
            stab_q  <= '0;
            press_q <= 1'b0;
        end else begin
            level_q <= level_d;
            stab_q  <= stab_d;
            press_q <= press_d;
        end
    end

    assign o_Press = press_q;

endmodule

// File: rtl/updn_counter_bcd.sv
// Push-button up/down counter with wrap or saturate mode, a sequential
// double-dabble BCD converter and per-digit 7-segment drive.
module updn_counter_bcd
    import cnt_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 99,
    parameter int STEP    = 1,
    parameter int NUM_DIG = 3,
    parameter int DEB_CYC = 1000000
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic [1:0]           i_Push,
    input  logic                 i_Mode,
    output logic [WIDTH-1:0]     o_Cnt,
    output logic                 o_Ovf,
    output logic [4*NUM_DIG-1:0] o_Bcd,
    output logic                 o_BcdValid,
    output logic [7*NUM_DIG-1:0] o_FND,
    output logic [1:0]           o_DbgState
);

    localparam int SHW = WIDTH + 4 * NUM_DIG;
    localparam int BW  = $clog2(WIDTH + 1);

    // Count arithmetic runs one bit wider so sums never overflow.
    localparam logic [WIDTH:0]   STEP_X = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH:0]   MAX_X  = (WIDTH + 1)'(MAX_VAL);
    localparam logic [WIDTH:0]   MOD_X  = (WIDTH + 1)'(MAX_VAL + 1);
    localparam logic [WIDTH-1:0] STEP_C = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);

    logic up_ev, dn_ev;

    push_debounce #(.DEB_CYC(DEB_CYC)) u_deb_up (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .i_Push (i_Push[1]),
        .o_Press(up_ev)
    );

    push_debounce #(.DEB_CYC(DEB_CYC)) u_deb_dn (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .i_Push (i_Push[0]),
        .o_Press(dn_ev)
    );

    // ---------------- count ----------------
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   cnt_x, up_sum;
    logic [WIDTH-1:0] up_wrap, dn_wrap;

    // Next count: one step per event, simultaneous up+down cancels.
    always_comb begin
        cnt_x   = {1'b0, cnt_q};
        up_sum  = cnt_x + STEP_X;
        up_wrap = WIDTH'(up_sum - MOD_X);
        dn_wrap = WIDTH'(cnt_x + MOD_X - STEP_X);
        cnt_d   = cnt_q;
        ovf_d   = 1'b0;
        if (up_ev && !dn_ev) begin
            if (up_sum > MAX_X) begin
                ovf_d = 1'b1;
                cnt_d = i_Mode ? MAX_C : up_wrap;
            end else begin
                cnt_d = up_sum[WIDTH-1:0];
            end
        end else if (dn_ev && !up_ev) begin
            if (cnt_x < STEP_X) begin
                ovf_d = 1'b1;
                cnt_d = i_Mode ? '0 : dn_wrap;
            end else begin
                cnt_d = cnt_q - STEP_C;
            end
        end
    end

    // Count and overflow-pulse registers.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // ---------------- BCD converter ----------------
    conv_state_e          state_q, state_d;
    logic [SHW-1:0]       sh_q, sh_d;
    logic [BW-1:0]        bitc_q, bitc_d;
    logic [WIDTH-1:0]     src_q, src_d;
    logic [4*NUM_DIG-1:0] bcd_q, bcd_d;
    logic                 valid_q, valid_d;
    logic                 chg;

    // One double-dabble iteration: adjust every digit >= 5, then shift left.
    function automatic logic [SHW-1:0] dabble_step(input logic [SHW-1:0] x);
        logic [SHW-1:0] s;
        s = x;
        for (int d = 0; d < NUM_DIG; d++) begin
            if (s[WIDTH+4*d +: 4] >= 4'd5) begin
                s[WIDTH+4*d +: 4] = s[WIDTH+4*d +: 4] + 4'd3;
            end
        end
        return {s[SHW-2:0], 1'b0};
    endfunction

    // src_q holds the value being (or last) converted; any difference means
    // the displayed BCD is stale and a (re)start is needed.
    assign chg = (cnt_q != src_q);

    // Converter next state; a count change in any state restarts from the new value.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bitc_d  = bitc_q;
        src_d   = src_q;
        bcd_d   = bcd_q;
        valid_d = valid_q;
        if (chg) begin
            src_d   = cnt_q;
            sh_d    = {{(4*NUM_DIG){1'b0}}, cnt_q};
            bitc_d  = '0;
            valid_d = 1'b0;
            state_d = SHIFT;
        end else begin
            case (state_q)
                SHIFT: begin
                    sh_d   = dabble_step(sh_q);
                    bitc_d = bitc_q + 1'b1;
                    if (bitc_q == BW'(WIDTH - 1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    bcd_d   = sh_q[SHW-1 -: 4*NUM_DIG];
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Converter registers.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            bitc_q  <= '0;
            src_q   <= '0;
            bcd_q   <= '0;
            valid_q <= 1'b1;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bitc_q  <= bitc_d;
            src_q   <= src_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
        end
    end

    // ---------------- outputs ----------------
    for (genvar g = 0; g < NUM_DIG; g++) begin : g_fnd
        assign o_FND[7*g +: 7] = seg_decode(bcd_q[4*g +: 4]);
    end

    assign o_Cnt      = cnt_q;
    assign o_Ovf      = ovf_q;
    assign o_Bcd      = bcd_q;
    assign o_BcdValid = valid_q && !chg;
    assign o_DbgState = state_q;

endmodule

// File: tb/tb_updn_counter_bcd.sv
// Bench for updn_counter_bcd: instance A uses STEP=1, instance B uses STEP=3.
module tb_updn_counter_bcd;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  push_a, push_b;
    logic        mode_a, mode_b;
    logic [7:0]  cnt_a, cnt_b;
    logic        ovf_a, ovf_b;
    logic [11:0] bcd_a, bcd_b;
    logic        valid_a, valid_b;
    logic [20:0] fnd_a, fnd_b;
    logic [1:0]  st_a, st_b;

    int n_pass  = 0;
    int n_total = 0;

    // scoreboard: expected {ovf,cnt} per output event, observed log from monitor
    logic [8:0] exp_a_q[$];
    logic [8:0] exp_b_q[$];
    logic [8:0] obs_a [256];
    logic [8:0] obs_b [256];
    int wr_a = 0, wr_b = 0, rd_a = 0, rd_b = 0;
    logic [7:0] prev_a = '0, prev_b = '0;
    int mdl_a = 0, mdl_b = 0;

    updn_counter_bcd #(.WIDTH(8), .MAX_VAL(99), .STEP(1), .NUM_DIG(3), .DEB_CYC(4)) dut_a (
        .i_Clk(clk), .i_Rst(rst), .i_Push(push_a), .i_Mode(mode_a),
        .o_Cnt(cnt_a), .o_Ovf(ovf_a), .o_Bcd(bcd_a), .o_BcdValid(valid_a),
        .o_FND(fnd_a), .o_DbgState(st_a)
    );

    updn_counter_bcd #(.WIDTH(8), .MAX_VAL(99), .STEP(3), .NUM_DIG(3), .DEB_CYC(4)) dut_b (
        .i_Clk(clk), .i_Rst(rst), .i_Push(push_b), .i_Mode(mode_b),
        .o_Cnt(cnt_b), .o_Ovf(ovf_b), .o_Bcd(bcd_b), .o_BcdValid(valid_b),
        .o_FND(fnd_b), .o_DbgState(st_b)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- monitor: log every count change or ovf pulse ----------------
    always @(negedge clk) begin
        if (rst) begin
            prev_a = '0;
            prev_b = '0;
        end else begin
            if (cnt_a !== prev_a || ovf_a === 1'b1) begin
                obs_a[wr_a[7:0]] = {ovf_a, cnt_a};
                wr_a++;
            end
            if (cnt_b !== prev_b || ovf_b === 1'b1) begin
                obs_b[wr_b[7:0]] = {ovf_b, cnt_b};
                wr_b++;
            end
            prev_a = cnt_a;
            prev_b = cnt_b;
        end
    end

    // ---------------- reference helpers ----------------
    function automatic logic [11:0] bcd_of(input int n);
        logic [3:0] h, t, o;
        h = 4'(n / 100);
        t = 4'((n / 10) % 10);
        o = 4'(n % 10);
        return {h, t, o};
    endfunction

    function automatic logic [6:0] exp_seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ev: [1]=up, [0]=down. Pushes the expected output event, if any.
    task automatic expect_step(input bit b, input logic [1:0] ev);
        int cur, stp, n;
        bit md, ov;
        cur = b ? mdl_b : mdl_a;
        stp = b ? 3 : 1;
        md  = b ? mode_b : mode_a;
        n   = cur;
        ov  = 1'b0;
        if (ev == 2'b10) begin
            n = cur + stp;
            if (n > 99) begin ov = 1'b1; n = md ? 99 : n - 100; end
        end else if (ev == 2'b01) begin
            n = cur - stp;
            if (n < 0) begin ov = 1'b1; n = md ? 0 : n + 100; end
        end
        if (ov || n != cur) begin
            if (b) exp_b_q.push_back({ov, 8'(n)});
            else   exp_a_q.push_back({ov, 8'(n)});
        end
        if (b) mdl_b = n; else mdl_a = n;
    endtask

    task automatic press(input bit b, input logic [1:0] ev, input int hold, input int gap);
        expect_step(b, ev);
        if (b) push_b = ~ev; else push_a = ~ev;
        cycles(hold);
        if (b) push_b = 2'b11; else push_a = 2'b11;
        cycles(gap);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        push_a = 2'b11;
        push_b = 2'b11;
        cycles(2);
        rst = 1'b0;
        mdl_a = 0;
        mdl_b = 0;
        exp_a_q.delete();
        exp_b_q.delete();
        cycles(1);
        rd_a = wr_a;
        rd_b = wr_b;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; push_a = 2'b11; push_b = 2'b11; mode_a = 1'b0; mode_b = 1'b0;
        cycles(3);
        n_total++; if (cnt_a !== 8'd0) $display("FAIL reset_cnt: got %0d expected 0", cnt_a); else n_pass++;
        n_total++; if (ovf_a !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", ovf_a); else n_pass++;
        n_total++; if (bcd_a !== 12'h000) $display("FAIL reset_bcd: got %h expected 000", bcd_a); else n_pass++;
        n_total++; if (valid_a !== 1'b1) $display("FAIL reset_valid: got %b expected 1", valid_a); else n_pass++;
        for (int g = 0; g < 3; g++) begin
            n_total++;
            if (fnd_a[7*g +: 7] !== 7'b1000000) $display("FAIL reset_fnd%0d: got %b expected 1000000", g, fnd_a[7*g +: 7]);
            else n_pass++;
        end
        n_total++; if (st_a !== 2'd0) $display("FAIL reset_state: got %0d expected 0", st_a); else n_pass++;
        n_total++; if (cnt_b !== 8'd0) $display("FAIL reset_cnt_b: got %0d expected 0", cnt_b); else n_pass++;
        rst = 1'b0;
        cycles(6);
        n_total++; if (cnt_a !== 8'd0 || valid_a !== 1'b1) $display("FAIL post_reset_idle: cnt=%0d valid=%b expected 0/1", cnt_a, valid_a); else n_pass++;
        rd_a = wr_a;
        rd_b = wr_b;
    endtask

    task automatic test_debounce();
        logic [8:0] e;
        // 3-cycle glitch must be ignored
        push_a = 2'b01;
        cycles(3);
        push_a = 2'b11;
        cycles(12);
        n_total++; if (cnt_a !== 8'd0 || rd_a != wr_a) $display("FAIL glitch: cnt=%0d events=%0d expected 0/0", cnt_a, wr_a - rd_a); else n_pass++;
        // clean 20-cycle press
        expect_step(1'b0, 2'b10);
        push_a = 2'b01;
        cycles(6);
        n_total++; if (cnt_a !== 8'd0) $display("FAIL deb_latency_early: got %0d expected 0", cnt_a); else n_pass++;
        cycles(1);
        n_total++; if (cnt_a !== 8'd1) $display("FAIL deb_latency: got %0d expected 1", cnt_a); else n_pass++;
        cycles(9);
        n_total++; if (valid_a !== 1'b0 || bcd_a !== 12'h000) $display("FAIL bcd_early: valid=%b bcd=%h expected 0/000", valid_a, bcd_a); else n_pass++;
        cycles(1);
        n_total++; if (valid_a !== 1'b1 || bcd_a !== 12'h001) $display("FAIL bcd_latency: valid=%b bcd=%h expected 1/001", valid_a, bcd_a); else n_pass++;
        n_total++; if (fnd_a[6:0] !== exp_seg(4'd1)) $display("FAIL fnd_one: got %b expected %b", fnd_a[6:0], exp_seg(4'd1)); else n_pass++;
        cycles(3);
        push_a = 2'b11;
        cycles(12);
        n_total++; if (cnt_a !== 8'd1) $display("FAIL hold_release: got %0d expected 1", cnt_a); else n_pass++;
        while (exp_a_q.size() > 0) begin
            e = exp_a_q.pop_front();
            n_total++;
            if (rd_a >= wr_a) $display("FAIL sb_a: no event, expected ovf=%0d cnt=%0d", e[8], e[7:0]);
            else begin
                if (obs_a[rd_a[7:0]] !== e) $display("FAIL sb_a: got ovf=%0d cnt=%0d expected ovf=%0d cnt=%0d", obs_a[rd_a[7:0]][8], obs_a[rd_a[7:0]][7:0], e[8], e[7:0]);
                else n_pass++;
                rd_a++;
            end
        end
        n_total++; if (rd_a != wr_a) $display("FAIL sb_a_extra: got %0d extra events expected 0", wr_a - rd_a); else n_pass++;
    endtask

    task automatic test_wrap_down();
        logic [8:0] e;
        mode_a = 1'b0;
        press(1'b0, 2'b01, 8, 8);
        press(1'b0, 2'b01, 8, 8);
        cycles(4);
        n_total++; if (cnt_a !== 8'd99) $display("FAIL wrap_down_cnt: got %0d expected 99", cnt_a); else n_pass++;
        n_total++; if (bcd_a !== bcd_of(99) || valid_a !== 1'b1) $display("FAIL wrap_down_bcd: bcd=%h valid=%b expected 099/1", bcd_a, valid_a); else n_pass++;
        n_total++; if (fnd_a[6:0] !== 7'b0010000) $display("FAIL fnd_d0_nine: got %b expected 0010000", fnd_a[6:0]); else n_pass++;
        n_total++; if (fnd_a[13:7] !== 7'b0010000) $display("FAIL fnd_d1_nine: got %b expected 0010000", fnd_a[13:7]); else n_pass++;
        n_total++; if (fnd_a[20:14] !== 7'b1000000) $display("FAIL fnd_d2_zero: got %b expected 1000000", fnd_a[20:14]); else n_pass++;
        while (exp_a_q.size() > 0) begin
            e = exp_a_q.pop_front();
            n_total++;
            if (rd_a >= wr_a) $display("FAIL sb_a: no event, expected ovf=%0d cnt=%0d", e[8], e[7:0]);
            else begin
                if (obs_a[rd_a[7:0]] !== e) $display("FAIL sb_a: got ovf=%0d cnt=%0d expected ovf=%0d cnt=%0d", obs_a[rd_a[7:0]][8], obs_a[rd_a[7:0]][7:0], e[8], e[7:0]);
                else n_pass++;
                rd_a++;
            end
        end
        n_total++; if (rd_a != wr_a) $display("FAIL sb_a_extra: got %0d extra events expected 0", wr_a - rd_a); else n_pass++;
    endtask

    task automatic test_both();
        press(1'b0, 2'b11, 8, 8);
        n_total++; if (cnt_a !== 8'd99) $display("FAIL both_cnt: got %0d expected 99", cnt_a); else n_pass++;
        n_total++; if (rd_a != wr_a || exp_a_q.size() != 0) $display("FAIL both_no_event: got %0d events expected 0", wr_a - rd_a); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [8:0] e;
        bit saw_bad;
        pulse_reset();
        for (int i = 0; i < 5; i++) press(1'b0, 2'b10, 8, 8);
        cycles(4);
        n_total++; if (bcd_a !== 12'h005 || valid_a !== 1'b1) $display("FAIL b2b_start: bcd=%h valid=%b expected 005/1", bcd_a, valid_a); else n_pass++;
        expect_step(1'b0, 2'b10);
        expect_step(1'b0, 2'b10);
        saw_bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 0 || i == 8) push_a = 2'b01;
            if (i == 4 || i == 12) push_a = 2'b11;
            cycles(1);
            if (bcd_a !== 12'h005 && bcd_a !== 12'h007) saw_bad = 1'b1;
        end
        n_total++; if (saw_bad) $display("FAIL b2b_abort: got intermediate bcd value expected only 005 then 007"); else n_pass++;
        n_total++; if (bcd_a !== 12'h007 || valid_a !== 1'b1) $display("FAIL b2b_final: bcd=%h valid=%b expected 007/1", bcd_a, valid_a); else n_pass++;
        while (exp_a_q.size() > 0) begin
            e = exp_a_q.pop_front();
            n_total++;
            if (rd_a >= wr_a) $display("FAIL sb_a: no event, expected ovf=%0d cnt=%0d", e[8], e[7:0]);
            else begin
                if (obs_a[rd_a[7:0]] !== e) $display("FAIL sb_a: got ovf=%0d cnt=%0d expected ovf=%0d cnt=%0d", obs_a[rd_a[7:0]][8], obs_a[rd_a[7:0]][7:0], e[8], e[7:0]);
                else n_pass++;
                rd_a++;
            end
        end
        n_total++; if (rd_a != wr_a) $display("FAIL sb_a_extra: got %0d extra events expected 0", wr_a - rd_a); else n_pass++;
    endtask

    task automatic test_step3();
        logic [8:0] e;
        mode_b = 1'b0;
        for (int i = 0; i < 34; i++) press(1'b1, 2'b01, 8, 8);
        n_total++; if (cnt_b !== 8'd98) $display("FAIL step3_reach98: got %0d expected 98", cnt_b); else n_pass++;
        press(1'b1, 2'b10, 8, 8);
        n_total++; if (cnt_b !== 8'd1) $display("FAIL step3_wrap_up: got %0d expected 1", cnt_b); else n_pass++;
        press(1'b1, 2'b01, 8, 8);
        mode_b = 1'b1;
        press(1'b1, 2'b10, 8, 8);
        n_total++; if (cnt_b !== 8'd99) $display("FAIL step3_sat: got %0d expected 99", cnt_b); else n_pass++;
        press(1'b1, 2'b10, 8, 8);
        n_total++; if (cnt_b !== 8'd99) $display("FAIL step3_sat_again: got %0d expected 99", cnt_b); else n_pass++;
        while (exp_b_q.size() > 0) begin
            e = exp_b_q.pop_front();
            n_total++;
            if (rd_b >= wr_b) $display("FAIL sb_b: no event, expected ovf=%0d cnt=%0d", e[8], e[7:0]);
            else begin
                if (obs_b[rd_b[7:0]] !== e) $display("FAIL sb_b: got ovf=%0d cnt=%0d expected ovf=%0d cnt=%0d", obs_b[rd_b[7:0]][8], obs_b[rd_b[7:0]][7:0], e[8], e[7:0]);
                else n_pass++;
                rd_b++;
            end
        end
        n_total++; if (rd_b != wr_b) $display("FAIL sb_b_extra: got %0d extra events expected 0", wr_b - rd_b); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [8:0] e;
        // mid-debounce, count and bcd currently 7
        push_a = 2'b01;
        cycles(3);
        rst = 1'b1;
        push_a = 2'b11;
        #1;
        n_total++; if (cnt_a !== 8'd0 || bcd_a !== 12'h000 || valid_a !== 1'b1) $display("FAIL rst_mid_deb: cnt=%0d bcd=%h valid=%b expected 0/000/1", cnt_a, bcd_a, valid_a); else n_pass++;
        cycles(2);
        rst = 1'b0;
        mdl_a = 0;
        cycles(1);
        rd_a = wr_a;
        cycles(20);
        n_total++; if (cnt_a !== 8'd0 || rd_a != wr_a) $display("FAIL rst_mid_deb_after: cnt=%0d events=%0d expected 0/0", cnt_a, wr_a - rd_a); else n_pass++;
        // mid-SHIFT
        expect_step(1'b0, 2'b10);
        push_a = 2'b01;
        cycles(4);
        push_a = 2'b11;
        cycles(7);
        n_total++; if (st_a !== 2'd1) $display("FAIL rst_mid_shift_pre: state=%0d expected 1", st_a); else n_pass++;
        rst = 1'b1;
        #1;
        n_total++; if (cnt_a !== 8'd0 || bcd_a !== 12'h000 || valid_a !== 1'b1 || st_a !== 2'd0) $display("FAIL rst_mid_shift: cnt=%0d bcd=%h valid=%b state=%0d expected 0/000/1/0", cnt_a, bcd_a, valid_a, st_a); else n_pass++;
        n_total++; if (fnd_a !== {3{7'b1000000}}) $display("FAIL rst_mid_shift_fnd: got %b expected all zero digits", fnd_a); else n_pass++;
        cycles(2);
        rst = 1'b0;
        mdl_a = 0;
        cycles(20);
        n_total++; if (cnt_a !== 8'd0 || valid_a !== 1'b1) $display("FAIL rst_mid_shift_after: cnt=%0d valid=%b expected 0/1", cnt_a, valid_a); else n_pass++;
        while (exp_a_q.size() > 0) begin
            e = exp_a_q.pop_front();
            n_total++;
            if (rd_a >= wr_a) $display("FAIL sb_a: no event, expected ovf=%0d cnt=%0d", e[8], e[7:0]);
            else begin
                if (obs_a[rd_a[7:0]] !== e) $display("FAIL sb_a: got ovf=%0d cnt=%0d expected ovf=%0d cnt=%0d", obs_a[rd_a[7:0]][8], obs_a[rd_a[7:0]][7:0], e[8], e[7:0]);
                else n_pass++;
                rd_a++;
            end
        end
        n_total++; if (rd_a != wr_a) $display("FAIL sb_a_extra: got %0d extra events expected 0", wr_a - rd_a); else n_pass++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_debounce();
        test_wrap_down();
        test_both();
        test_back_to_back();
        test_step3();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
